// File: rtl/ulx3s_lock_supervisor.sv
// rtl/ulx3s_lock_supervisor.sv - PLL lock qualification and domain reset sequencer
// Optional lock-loss event counter is built when LOCK_LOSS_COUNT_EN is defined.
module ulx3s_lock_supervisor #(
   parameter int unsigned STABLE_CYCLES = 1024,
   parameter int unsigned HOLD_CYCLES   = 16
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       locked,
   output logic       sys_reset,
   output logic       ready,
   output logic [1:0] state
`ifdef LOCK_LOSS_COUNT_EN
   ,
   output logic [7:0] lock_loss_count
`endif
);

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABILISE = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } state_t;

   localparam logic [15:0] STABLE_LAST = 16'(STABLE_CYCLES - 1);
   localparam logic [15:0] HOLD_LAST   = 16'(HOLD_CYCLES - 1);

   logic        locked_m;
   logic        locked_s;
   state_t      cur_state;
   state_t      nxt_state;
   logic [15:0] cnt;
   logic [15:0] nxt_cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         locked_m <= 1'b0;
         locked_s <= 1'b0;
      end else begin
         locked_m <= locked;
         locked_s <= locked_m;
      end
   end

   // Any low cycle of locked_s drops straight back to WAIT_LOCK with a cleared counter.
   always_comb begin
      nxt_state = cur_state;
      nxt_cnt   = 16'd0;
      case (cur_state)
         WAIT_LOCK: begin
            if (locked_s) nxt_state = STABILISE;
         end
         STABILISE: begin
            if (!locked_s)                nxt_state = WAIT_LOCK;
            else if (cnt == STABLE_LAST)  nxt_state = HOLD;
            else                          nxt_cnt   = cnt + 16'd1;
         end
         HOLD: begin
            if (!locked_s)                nxt_state = WAIT_LOCK;
            else if (cnt == HOLD_LAST)    nxt_state = RUN;
            else                          nxt_cnt   = cnt + 16'd1;
         end
         RUN: begin
            if (!locked_s) nxt_state = WAIT_LOCK;
         end
         default: nxt_state = WAIT_LOCK;
      endcase
   end

   // Outputs are registered from the next state so they switch on the same edge as state.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         cur_state <= WAIT_LOCK;
         cnt       <= 16'd0;
         sys_reset <= 1'b1;
         ready     <= 1'b0;
      end else begin
         cur_state <= nxt_state;
         cnt       <= nxt_cnt;
         sys_reset <= (nxt_state != RUN);
         ready     <= (nxt_state == RUN);
      end
   end

   assign state = cur_state;

`ifdef LOCK_LOSS_COUNT_EN
   logic [7:0] loss_cnt;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         loss_cnt <= 8'd0;
      else if ((cur_state == RUN) && !locked_s && (loss_cnt != 8'hFF))
         loss_cnt <= loss_cnt + 8'd1;
   end

   assign lock_loss_count = loss_cnt;
`endif

endmodule
